// File: rtl/riscv_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time, buffers
// up to two fetched words for decode and flushes on downstream redirects.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd_w,
  output logic [31:0] fetch_pc_w,
  input  logic        mem_accept_w,
  input  logic        mem_valid_w,
  input  logic [31:0] mem_data_w,
  input  logic        mem_error_w,
  input  logic        branch_request_w,
  input  logic [31:0] branch_pc_w,
  output logic        if_valid_w,
  output logic [31:0] if_opcode_w,
  output logic [31:0] if_pc_w,
  output logic        if_fault_w,
  input  logic        fetch_accept_w,
  output logic [1:0]  dbg_state_w
);

  // Handshakes: a memory request transfers on an edge where mem_rd_w & mem_accept_w;
  // a buffered instruction transfers to decode on an edge where if_valid_w & fetch_accept_w.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_op_q [2];
  logic [31:0] buf_op_d [2];
  logic        buf_fault_q [2];
  logic        buf_fault_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic redirect;
  logic push;
  logic pop;

  assign fetch_pc_w  = pc_q;
  assign dbg_state_w = state_q;
  assign if_valid_w  = (count_q != 2'd0);
  assign if_opcode_w = if_valid_w ? buf_op_q[rd_ptr_q] : 32'h0;
  assign if_pc_w     = if_valid_w ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign if_fault_w  = if_valid_w ? buf_fault_q[rd_ptr_q] : 1'b0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_op_d    = buf_op_q;
    buf_fault_d = buf_fault_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    redirect = branch_request_w && (state_q != ST_RESET);
    mem_rd_w = (state_q == ST_FETCH) && (count_q != 2'd2) && !branch_request_w;
    push     = (state_q == ST_WAIT) && mem_valid_w && !redirect;
    pop      = if_valid_w && fetch_accept_w && !redirect;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_rd_w && mem_accept_w) begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT:  if (mem_valid_w) state_d = ST_FETCH;
      // A response consumed here is the one being discarded, even alongside a new redirect.
      ST_DROP:  if (mem_valid_w) state_d = ST_FETCH;
      default:  state_d = ST_RESET;
    endcase

    if (push) begin
      buf_pc_d[wr_ptr_q]    = pend_pc_q;
      buf_op_d[wr_ptr_q]    = mem_error_w ? 32'h0 : mem_data_w;
      buf_fault_d[wr_ptr_q] = mem_error_w;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (redirect) begin
      pc_d     = branch_pc_w & 32'hFFFF_FFFC;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
      if (state_q == ST_WAIT && !mem_valid_w) state_d = ST_DROP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      pc_q        <= RESET_PC;
      pend_pc_q   <= 32'h0;
      buf_pc_q    <= '{default: '0};
      buf_op_q    <= '{default: '0};
      buf_fault_q <= '{default: 1'b0};
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_op_q    <= buf_op_d;
      buf_fault_q <= buf_fault_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: behavioural instruction memory, program-order stream model,
// scoreboard queue and a decoupled output monitor.
module tb_riscv_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_w;
  logic [31:0] fetch_pc_w;
  logic        mem_accept_w;
  logic        mem_valid_w;
  logic [31:0] mem_data_w;
  logic        mem_error_w;
  logic        branch_request_w;
  logic [31:0] branch_pc_w;
  logic        if_valid_w;
  logic [31:0] if_opcode_w;
  logic [31:0] if_pc_w;
  logic        if_fault_w;
  logic        fetch_accept_w;
  logic [1:0]  dbg_state_w;

  riscv_fetch dut (
    .clk(clk), .rst(rst),
    .mem_rd_w(mem_rd_w), .fetch_pc_w(fetch_pc_w),
    .mem_accept_w(mem_accept_w), .mem_valid_w(mem_valid_w),
    .mem_data_w(mem_data_w), .mem_error_w(mem_error_w),
    .branch_request_w(branch_request_w), .branch_pc_w(branch_pc_w),
    .if_valid_w(if_valid_w), .if_opcode_w(if_opcode_w), .if_pc_w(if_pc_w),
    .if_fault_w(if_fault_w), .fetch_accept_w(fetch_accept_w),
    .dbg_state_w(dbg_state_w)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // scoreboard entry: {pc, opcode, fault}
  logic [64:0] exp_q[$];
  logic [31:0] pop_hist[$];
  logic [64:0] mon_e;
  logic        prev_br = 1'b0;
  int          n_pop = 0;
  int          n_fault = 0;
  logic [31:0] fault_pc = 32'h0;

  // program-order model and memory model state
  logic [31:0] next_pc = 32'h0;
  bit          mem_busy = 1'b0;
  int          rem = 0;
  logic [31:0] rsp_data = 32'h0;
  logic        rsp_err = 1'b0;

  int          lat_min = 1, lat_max = 1, acc_pct = 100, fa_mode = 1;
  int          br_mode = 0, br_pct = 0;
  logic [31:0] br_tgt = 32'h0;
  bit          br_done = 1'b0;
  bit          err_en = 1'b0, err_rand = 1'b0;
  logic [31:0] err_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00000293;
      32'h4:   return 32'h00a00393;
      32'h8:   return 32'h0072d463;
      32'hC:   return 32'h00128293;
      default: return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endcase
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return (err_en && a == err_addr) || (err_rand && a[4:2] == 3'b101);
  endfunction

  // driver: one call per clock; drives at the falling edge, updates model for the next rising edge
  task automatic step();
    logic br;
    logic [31:0] tpc;
    @(negedge clk);
    mem_valid_w = 1'b0;
    mem_data_w  = 32'h0;
    mem_error_w = 1'b0;
    if (mem_busy) begin
      rem--;
      if (rem == 0) begin
        mem_valid_w = 1'b1;
        mem_data_w  = rsp_data;
        mem_error_w = rsp_err;
        mem_busy    = 1'b0;
      end
    end
    case (br_mode)
      1: br = 1'b1;
      2: br = mem_valid_w && if_valid_w;
      3: begin
        br = ($urandom_range(0, 99) < br_pct);
        br_tgt = $urandom_range(0, 1023);
      end
      default: br = 1'b0;
    endcase
    br_done = br;
    branch_request_w = br;
    branch_pc_w      = br ? br_tgt : $urandom;
    mem_accept_w     = ($urandom_range(0, 99) < acc_pct);
    fetch_accept_w   = (fa_mode == 2) ? 1'($urandom_range(0, 1)) : (fa_mode == 1);
    #1;
    if (br) begin
      exp_q.delete();
      next_pc = br_tgt & 32'hFFFF_FFFC;
    end
    chk("rd_while_outstanding", {31'b0, mem_rd_w & mem_busy}, 32'h0);
    if (!mem_busy && exp_q.size() >= 2) chk("rd_when_full", {31'b0, mem_rd_w}, 32'h0);
    if (mem_rd_w) chk("req_pc", fetch_pc_w, next_pc);
    if (mem_rd_w && mem_accept_w) begin
      tpc = next_pc;
      exp_q.push_back({tpc, is_err(tpc) ? 32'h0 : word(tpc), is_err(tpc)});
      rsp_data = word(fetch_pc_w);
      rsp_err  = is_err(fetch_pc_w);
      rem      = $urandom_range(lat_min, lat_max);
      mem_busy = 1'b1;
      next_pc  = next_pc + 32'd4;
    end
    #2;
  endtask

  task automatic clear_model();
    mem_busy = 1'b0;
    exp_q.delete();
    pop_hist.delete();
    next_pc = 32'h0;
    n_fault = 0;
  endtask

  task automatic quiet_inputs();
    mem_accept_w = 1'b0; mem_valid_w = 1'b0; mem_data_w = 32'h0; mem_error_w = 1'b0;
    branch_request_w = 1'b0; branch_pc_w = 32'h0; fetch_accept_w = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    quiet_inputs();
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor: pops the scoreboard whenever decode takes the head entry
  always @(negedge clk) begin
    #2;
    if (rst !== 1'b1) begin
      prev_br = 1'b0;
    end else begin
      if (prev_br) chk("flush_after_redirect", {31'b0, if_valid_w}, 32'h0);
      if (if_valid_w) begin
        if (fetch_accept_w && !branch_request_w) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual_pc=%h expected=none", if_pc_w);
          end else begin
            mon_e = exp_q.pop_front();
            chk("out_pc", if_pc_w, mon_e[64:33]);
            chk("out_opcode", if_opcode_w, mon_e[32:1]);
            chk("out_fault", {31'b0, if_fault_w}, {31'b0, mon_e[0]});
            pop_hist.push_back(if_pc_w);
            if (if_fault_w) begin
              n_fault++;
              fault_pc = if_pc_w;
            end
            n_pop++;
          end
        end
      end else begin
        chk("empty_opcode", if_opcode_w, 32'h0);
        chk("empty_pc", if_pc_w, 32'h0);
        chk("empty_fault", {31'b0, if_fault_w}, 32'h0);
      end
      prev_br = branch_request_w;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_rd"}, {31'b0, mem_rd_w}, 32'h0);
    chk({tag, "_fetch_pc"}, fetch_pc_w, 32'h0);
    chk({tag, "_if_valid"}, {31'b0, if_valid_w}, 32'h0);
    chk({tag, "_if_opcode"}, if_opcode_w, 32'h0);
    chk({tag, "_if_pc"}, if_pc_w, 32'h0);
    chk({tag, "_if_fault"}, {31'b0, if_fault_w}, 32'h0);
    chk({tag, "_state"}, {30'b0, dbg_state_w}, 32'h0);
  endtask

  initial begin
    int steps;
    rst = 1'b1;
    quiet_inputs();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // zero-wait memory, decode always ready
    rst = 1'b1;
    steps = 0;
    while (n_pop < 4 && steps < 20) begin step(); steps++; end
    chk("zero_wait_throughput_steps", steps, 32'd9);
    chk("a_pc0", pop_hist[0], 32'h0);
    chk("a_pc3", pop_hist[3], 32'hC);

    // decode stalled from reset
    do_reset();
    fa_mode = 0;
    repeat (12) step();
    chk("stall_mem_rd", {31'b0, mem_rd_w}, 32'h0);
    chk("stall_if_valid", {31'b0, if_valid_w}, 32'h1);
    chk("stall_if_pc", if_pc_w, 32'h0);
    chk("stall_if_opcode", if_opcode_w, 32'h00000293);
    fa_mode = 1;
    steps = 0;
    while (pop_hist.size() < 3 && steps < 30) begin step(); steps++; end
    chk("resume_pc0", pop_hist[0], 32'h0);
    chk("resume_pc1", pop_hist[1], 32'h4);
    chk("resume_pc2", pop_hist[2], 32'h8);

    // redirect while a 3-cycle read is in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    steps = 0;
    while (!mem_busy && steps < 10) begin step(); steps++; end
    br_tgt = 32'h0000_0103; br_mode = 1;
    step();
    br_mode = 0;
    step();
    chk("wait_redirect_fetch_pc", fetch_pc_w, 32'h100);
    steps = 0;
    while (pop_hist.size() < 1 && steps < 30) begin step(); steps++; end
    chk("wait_redirect_first_pc", pop_hist[0], 32'h100);

    // redirect coinciding with a response, buffer non-empty
    do_reset();
    lat_min = 2; lat_max = 2; fa_mode = 0;
    br_tgt = 32'h0000_0200; br_mode = 2;
    steps = 0;
    br_done = 1'b0;
    while (!br_done && steps < 20) begin step(); steps++; end
    chk("valid_redirect_issued", {31'b0, br_done}, 32'h1);
    br_mode = 0; fa_mode = 1;
    step();
    chk("valid_redirect_empty", {31'b0, if_valid_w}, 32'h0);
    chk("valid_redirect_fetch_pc", fetch_pc_w, 32'h200);
    chk("valid_redirect_mem_rd", {31'b0, mem_rd_w}, 32'h1);
    steps = 0;
    while (pop_hist.size() < 1 && steps < 20) begin step(); steps++; end
    chk("valid_redirect_first_pc", pop_hist[0], 32'h200);

    // bus error at pc 8
    do_reset();
    lat_min = 1; lat_max = 2; err_en = 1'b1; err_addr = 32'h8;
    steps = 0;
    while (pop_hist.size() < 4 && steps < 40) begin step(); steps++; end
    chk("fault_count", n_fault, 32'd1);
    chk("fault_pc", fault_pc, 32'h8);
    err_en = 1'b0;

    // redirect to the top word wraps to zero
    br_tgt = 32'hFFFF_FFFE; br_mode = 1;
    step();
    br_mode = 0;
    pop_hist.delete();
    steps = 0;
    while (pop_hist.size() < 2 && steps < 40) begin step(); steps++; end
    chk("wrap_pc0", pop_hist[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", pop_hist[1], 32'h0);

    // reset asserted while a read is outstanding
    lat_min = 3; lat_max = 4; fa_mode = 2;
    repeat (3) step();
    steps = 0;
    while (!mem_busy && steps < 10) begin step(); steps++; end
    step();
    rst = 1'b0;
    quiet_inputs();
    #1;
    check_reset_outputs("midreset");
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat_min = 1; lat_max = 1; fa_mode = 1;
    steps = 0;
    while (pop_hist.size() < 2 && steps < 30) begin step(); steps++; end
    chk("restart_pc0", pop_hist[0], 32'h0);
    chk("restart_pc1", pop_hist[1], 32'h4);

    // random soak
    lat_min = 1; lat_max = 4; acc_pct = 70; fa_mode = 2;
    br_mode = 3; br_pct = 4; err_rand = 1'b1;
    repeat (1500) step();
    br_mode = 0; fa_mode = 1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
